avalon_button_capture: RTL



---
 rtl/avalon_button_capture.sv | 114 +++++++++++
 1 files changed

// File: rtl/avalon_button_capture.sv
// Debounced push-button capture peripheral on Avalon-MM.
// Level, sticky press flags with W1C, irq mask and a saturating press counter.
module avalon_button_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync0_q, sync0_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [15:0]      count_q, count_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rv;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_comb begin
    sync0_d  = ~buttons_in;
    sync1_d  = sync0_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync1_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        stable_d[i] = sync1_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    press = stable_d & ~stable_q;
  end

  // Press beats a same-cycle clear on both EDGE and COUNT.
  always_comb begin
    mask_d  = mask_q;
    clr     = '0;
    count_d = count_q;
    if (avs_write && avs_address == 2'd1) begin
      mask_d = avs_writedata[WIDTH-1:0];
    end
    if (avs_write && avs_address == 2'd2) begin
      clr = avs_writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~clr) | press;
    if (avs_write && avs_address == 2'd3) begin
      count_d = (|press) ? 16'd1 : 16'd0;
    end else if ((|press) && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_comb begin
    rv = '0;
    case (avs_address)
      2'd0: rv[WIDTH-1:0] = stable_q;
      2'd1: rv[WIDTH-1:0] = mask_q;
      2'd2: rv[WIDTH-1:0] = edge_q;
      2'd3: rv[15:0]      = count_q;
      default: rv = '0;
    endcase
    rdata_d = avs_read ? rv : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q  <= '0;
      sync1_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      mask_q   <= '0;
      edge_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      sync0_q  <= sync0_d;
      sync1_q  <= sync1_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = |(edge_q & mask_q);

endmodule
